// File: rtl/pipe_arith_pkg.sv
// -----------------------------------------------------------------------------
// pipe_arith_pkg
// Shared constants and helpers for the pipelined select/add datapath.
//   OP_ADD / OP_SUB : encodings of the 'sub' control bit.
//   DEFAULT_WIDTH   : default operand/result width.
//   DEFAULT_NUM_IN  : default number of candidates per select.
//   sel_width()     : ceil(log2(n)) with a floor of 1, used to size and
//                     validate select indices.
// -----------------------------------------------------------------------------
package pipe_arith_pkg;

    localparam logic OP_ADD         = 1'b0;
    localparam logic OP_SUB         = 1'b1;
    localparam int   DEFAULT_WIDTH  = 32;
    localparam int   DEFAULT_NUM_IN = 4;

    // Number of bits needed to index n candidates (at least one bit).
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipe_sel_adder_if.sv
// -----------------------------------------------------------------------------
// pipe_sel_adder_if
// Bundles the operand/control inputs and the elastic result handshake of
// pipe_sel_adder.
//   flush                : kill everything in flight (upstream -> block)
//   in_valid / in_ready  : operation handshake
//   a_data / a_sel       : A candidates (candidate i at [i*WIDTH +: WIDTH]) and index
//   b_data / b_sel       : B candidates and index
//   sub                  : 0 = A+B, 1 = A-B
//   out_valid / out_ready: result handshake
//   out_sum / out_carry  : result; for subtract carry=1 means no borrow
// Modports:
//   master : the environment driving operations and consuming results
//   slave  : the pipe_sel_adder block
// -----------------------------------------------------------------------------
interface pipe_sel_adder_if
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = 2
) ();

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] a_data;
    logic [SEL_W-1:0]        a_sel;
    logic [NUM_IN*WIDTH-1:0] b_data;
    logic [SEL_W-1:0]        b_sel;
    logic                    sub;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_sum;
    logic                    out_carry;

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output a_data,
        output a_sel,
        output b_data,
        output b_sel,
        output sub,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_carry
    );

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  a_data,
        input  a_sel,
        input  b_data,
        input  b_sel,
        input  sub,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_carry
    );

endinterface

// File: rtl/pipe_sel_adder_mux_n.sv
// -----------------------------------------------------------------------------
// mux_n
// Combinational N-way operand select. An index that does not name a
// candidate (possible when NUM_IN is not a power of two) yields all zeros.
//   data_i : NUM_IN packed candidates, candidate i at [i*WIDTH +: WIDTH]
//   sel_i  : candidate index
//   data_o : selected candidate, or zero when sel_i >= NUM_IN
// -----------------------------------------------------------------------------
module mux_n
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        data_o
);

    logic [WIDTH-1:0]  cand [NUM_IN];
    logic [NUM_IN-1:0] hit;

    // One decoded hit per candidate; an out-of-range index matches none of
    // them, which is what produces the all-zero result.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
        assign cand[gi] = data_i[gi*WIDTH +: WIDTH];
        assign hit[gi]  = (sel_i == SEL_W'(gi));
    end

    // AND-OR reduction: hit is at most one-hot, so no priority chain needed.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            data_o = data_o | ({WIDTH{hit[i]}} & cand[i]);
        end
    end

endmodule

// File: rtl/pipe_sel_adder.sv
// -----------------------------------------------------------------------------
// pipe_sel_adder
// Two-stage pipelined operand select + add/subtract with an elastic
// valid/ready handshake, stall and flush.
//   S1 registers the selected A, the selected B and the sub bit.
//   S2 registers {carry, sum} = A + (sub ? ~B : B) + sub.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; clears valid bits and all data
//   bus : pipe_sel_adder_if.slave (operands, controls, handshakes, result)
// The interface instance must be built with the same WIDTH/NUM_IN/SEL_W.
// -----------------------------------------------------------------------------
module pipe_sel_adder
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    pipe_sel_adder_if.slave  bus
);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    if (SEL_W != sel_width(NUM_IN)) begin : g_bad_sel_w
        $error("pipe_sel_adder: SEL_W must equal clog2(NUM_IN)");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("pipe_sel_adder: WIDTH must be at least 2");
    end
    if (NUM_IN < 2) begin : g_bad_num_in
        $error("pipe_sel_adder: NUM_IN must be at least 2");
    end

    // ---------------------------------------------------------------------
    // Operand selection
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] a_pick;
    logic [WIDTH-1:0] b_pick;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux_a (
        .data_i (bus.a_data),
        .sel_i  (bus.a_sel),
        .data_o (a_pick)
    );

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux_b (
        .data_i (bus.b_data),
        .sel_i  (bus.b_sel),
        .data_o (b_pick)
    );

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s1_sub_q,   s1_sub_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sum_q,   s2_sum_d;
    logic             s2_carry_q, s2_carry_d;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s1_load;
    logic s2_load;
    logic in_ready_int;

    // S2 can take S1's operation when it is empty or is emptying this cycle.
    assign s2_load      = s1_valid_q & (~s2_valid_q | bus.out_ready);
    // Depends on out_ready (through s2_load) so a full pipe restarts without
    // a bubble; deliberately independent of in_valid.
    assign in_ready_int = ~bus.flush & (~s1_valid_q | s2_load);
    assign s1_load      = bus.in_valid & in_ready_int;

    // ---------------------------------------------------------------------
    // Add/subtract at WIDTH+1 bits; subtract is A + ~B + 1 so the carry-out
    // reads as "no borrow".
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_res;

    assign b_eff   = (s1_sub_q == OP_SUB) ? ~s1_b_q : s1_b_q;
    assign add_res = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, s1_sub_q};

    // ---------------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
        s2_valid_d = s2_load | (s2_valid_q & ~bus.out_ready);
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sub_d   = s1_sub_q;
        s2_sum_d   = s2_sum_q;
        s2_carry_d = s2_carry_q;

        // Flush only kills the valid bits; data registers keep moving on
        // their own load conditions and are simply ignored afterwards.
        if (bus.flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        if (s1_load) begin
            s1_a_d   = a_pick;
            s1_b_d   = b_pick;
            s1_sub_d = bus.sub;
        end

        if (s2_load) begin
            s2_sum_d   = add_res[WIDTH-1:0];
            s2_carry_d = add_res[WIDTH];
        end
    end

    // ---------------------------------------------------------------------
    // Registers: reset clears everything and overrides flush/handshake.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sub_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_carry_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sub_q   <= s1_sub_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_carry_q <= s2_carry_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sum   = s2_sum_q;
    assign bus.out_carry = s2_carry_q;

endmodule

// File: tb/tb_pipe_sel_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_sel_adder
// Self-checking bench for pipe_sel_adder. A queue of expected {carry,sum}
// values is computed with plain arithmetic from the operands offered at each
// accepted handshake and compared against every presented result. A second
// instance with NUM_IN=3 covers the out-of-range select rule.
// -----------------------------------------------------------------------------
module tb_pipe_sel_adder;

    localparam int W = 32;
    localparam int N = 4;

    logic clk;
    logic rst;

    pipe_sel_adder_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(2)) bus  ();
    pipe_sel_adder_if #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) bus3 ();

    pipe_sel_adder #(.WIDTH(W), .NUM_IN(N), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_sel_adder #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          xfer_cnt = 0;
    logic        acc;
    logic        xf;
    logic [32:0] exp_q [$];

    // -------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: select rule plus plain add / subtract with borrow test.
    function automatic logic [32:0] ref_result();
        logic [31:0] a;
        logic [31:0] b;
        a = '0;
        b = '0;
        if (int'(bus.a_sel) < N) a = bus.a_data[int'(bus.a_sel)*W +: W];
        if (int'(bus.b_sel) < N) b = bus.b_data[int'(bus.b_sel)*W +: W];
        if (bus.sub) return {(a >= b), a - b};
        else         return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic rand_op();
        for (int i = 0; i < N; i++) begin
            bus.a_data[i*W +: W] = $urandom;
            bus.b_data[i*W +: W] = $urandom;
        end
        bus.a_sel = 2'($urandom_range(0, 3));
        bus.b_sel = 2'($urandom_range(0, 3));
        bus.sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic set_op(input logic [31:0] a, input logic [1:0] as,
                          input logic [31:0] b, input logic [1:0] bs, input logic s);
        rand_op();
        bus.a_data[int'(as)*W +: W] = a;
        bus.b_data[int'(bs)*W +: W] = b;
        bus.a_sel = as;
        bus.b_sel = bs;
        bus.sub   = s;
    endtask

    // One clock: sample handshakes at the falling edge, update the model,
    // then return 1 time unit after the next rising edge.
    task automatic cycle();
        logic [32:0] front;
        @(negedge clk);
        acc = bus.in_valid & bus.in_ready;
        xf  = bus.out_valid & bus.out_ready;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    front = exp_q[0];
                    chk("out_sum", 64'(bus.out_sum), 64'(front[31:0]));
                    chk("out_carry", 64'(bus.out_carry), 64'(front[32]));
                    if (xf) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
            if (bus.flush) begin
                chk("in_ready_in_flush", 64'(bus.in_ready), 64'd0);
                exp_q.delete();
            end
            if (acc) exp_q.push_back(ref_result());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] s, input logic c);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_sum"},   64'(bus.out_sum),   64'(s));
        chk({tag, "_carry"}, 64'(bus.out_carry), 64'(c));
    endtask

    task automatic fill_two();
        int got;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            cycle();
            if (acc) begin
                got++;
                rand_op();
            end
        end
        chk("fill_two_accepted", 64'(got), 64'd2);
    endtask

    // -------------------------------------------------------------------------
    initial begin
        int          accepted;
        int          xf_base;
        logic [31:0] held;
        logic [31:0] oor_sum [3];
        logic        oor_car [3];
        logic [1:0]  oor_asel [3];
        logic [1:0]  oor_bsel [3];
        logic        oor_sub [3];

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        rand_op();
        bus3.flush     = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 1'b1;
        bus3.a_data    = '0;
        bus3.b_data    = '0;
        bus3.a_sel     = '0;
        bus3.b_sel     = '0;
        bus3.sub       = 1'b0;

        // ---- reset: outputs zero, op offered during reset is dropped ----
        repeat (2) begin
            cycle();
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_out_sum",   64'(bus.out_sum),   64'd0);
            chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
            chk("rst_out_valid3", 64'(bus3.out_valid), 64'd0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        cycle();
        chk("post_rst_empty", 64'(bus.out_valid), 64'd0);

        // ---- latency: 0x10 + 0x5 ----
        set_op(32'h0000_0010, 2'd1, 32'h0000_0005, 2'd2, 1'b0);
        bus.in_valid = 1'b1;
        cycle();
        chk("lat_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        chk("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
        cycle();
        expect_out("lat_edge2", 32'h0000_0015, 1'b0);
        cycle();

        // ---- subtract with borrow, add with wrap ----
        set_op(32'h0000_0003, 2'd0, 32'h0000_0005, 2'd3, 1'b1);
        bus.in_valid = 1'b1;
        cycle();
        set_op(32'hFFFF_FFFF, 2'd2, 32'h0000_0001, 2'd1, 1'b0);
        cycle();
        bus.in_valid = 1'b0;
        expect_out("sub_borrow", 32'hFFFF_FFFE, 1'b0);
        cycle();
        expect_out("add_wrap", 32'h0000_0000, 1'b1);
        cycle();

        // ---- back-pressure: 6 ops, stall after 2 ----
        bus.out_ready = 1'b0;
        rand_op();
        bus.in_valid = 1'b1;
        fill_two();
        accepted = 2;
        chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        held = bus.out_sum;
        repeat (3) begin
            cycle();
            chk("bp_stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_stall_sum_stable", 64'(bus.out_sum), 64'(held));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        xf_base = xfer_cnt;
        for (int c = 0; c < 6; c++) begin
            chk("bp_drain_valid", 64'(bus.out_valid), 64'd1);
            cycle();
            if (acc) begin
                accepted++;
                if (accepted == 6) bus.in_valid = 1'b0;
                else               rand_op();
            end
        end
        chk("bp_accepted", 64'(accepted), 64'd6);
        chk("bp_results", 64'(xfer_cnt - xf_base), 64'd6);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---- flush with result stalled: nothing emerges ----
        rand_op();
        bus.in_valid = 1'b1;
        fill_two();
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        xf_base       = xfer_cnt;
        cycle();
        bus.flush = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("flush_next_in_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        chk("flush_next_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        repeat (3) cycle();
        chk("flush_one_result", 64'(xfer_cnt - xf_base), 64'd1);

        // ---- flush while the S2 result transfers: that result counts ----
        rand_op();
        bus.in_valid = 1'b1;
        fill_two();
        bus.flush = 1'b1;
        xf_base   = xfer_cnt;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_xfer_counted", 64'(xfer_cnt - xf_base), 64'd1);
        chk("flush_xfer_out_valid", 64'(bus.out_valid), 64'd0);
        cycle();

        // ---- reset during a stalled full pipe ----
        bus.out_ready = 1'b0;
        rand_op();
        bus.in_valid = 1'b1;
        fill_two();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_sum",   64'(bus.out_sum),   64'd0);
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        set_op(32'h0000_0007, 2'd0, 32'h0000_0008, 2'd0, 1'b0);
        cycle();
        chk("mid_rst_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        chk("mid_rst_edge1_valid", 64'(bus.out_valid), 64'd0);
        cycle();
        expect_out("mid_rst_edge2", 32'h0000_000F, 1'b0);
        cycle();

        // ---- full throughput with out_ready held high ----
        xf_base = xfer_cnt;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rand_op();
            chk("tput_in_ready", 64'(bus.in_ready), 64'd1);
            if (c >= 2) chk("tput_out_valid", 64'(bus.out_valid), 64'd1);
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (2) cycle();
        chk("tput_results", 64'(xfer_cnt - xf_base), 64'd10);

        // ---- randomized traffic with occasional flush ----
        for (int c = 0; c < 300; c++) begin
            rand_op();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle();
        chk("rand_drain_empty", 64'(exp_q.size()), 64'd0);
        cycle();
        chk("rand_drain_out_valid", 64'(bus.out_valid), 64'd0);

        // ---- NUM_IN=3: index 3 selects zero ----
        bus3.a_data = {32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
        bus3.b_data = {32'h0000_0044, 32'h0000_0055, 32'h0000_0007};
        oor_asel[0] = 2'd3; oor_bsel[0] = 2'd0; oor_sub[0] = 1'b0; oor_sum[0] = 32'h0000_0007; oor_car[0] = 1'b0;
        oor_asel[1] = 2'd2; oor_bsel[1] = 2'd3; oor_sub[1] = 1'b1; oor_sum[1] = 32'h0000_0011; oor_car[1] = 1'b1;
        oor_asel[2] = 2'd3; oor_bsel[2] = 2'd0; oor_sub[2] = 1'b1; oor_sum[2] = 32'hFFFF_FFF9; oor_car[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus3.a_sel    = oor_asel[k];
            bus3.b_sel    = oor_bsel[k];
            bus3.sub      = oor_sub[k];
            bus3.in_valid = 1'b1;
            #1;
            chk("oor_in_ready", 64'(bus3.in_ready), 64'd1);
            cycle();
            bus3.in_valid = 1'b0;
            cycle();
            chk("oor_out_valid", 64'(bus3.out_valid), 64'd1);
            chk("oor_out_sum",   64'(bus3.out_sum),   64'(oor_sum[k]));
            chk("oor_out_carry", 64'(bus3.out_carry), 64'(oor_car[k]));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_sel_adder.md
Name: pipe_sel_adder

Overview:
- Parametrised, pipelined successor to the single-cycle 2:1/3:1 mux plus adder path used for operand forwarding and address generation.
- Two independent N-way operand selects feed a registered add/subtract datapath.
- Elastic valid/ready handshake with stall and flush.
- Sits between ID/EX forwarding sources and the EX/MEM boundary; also used for PC+offset and branch-target generation.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2).
- NUM_IN, 4, number of candidate operands per select (>=2).
- SEL_W, 2, select width; must equal clog2(NUM_IN); elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill all in-flight operations.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block accepts an operation this cycle.
- a_data  input  NUM_IN*WIDTH  A candidates, candidate i at bits [i*WIDTH +: WIDTH].
- a_sel  input  SEL_W  A select index.
- b_data  input  NUM_IN*WIDTH  B candidates, same packing as a_data.
- b_sel  input  SEL_W  B select index.
- sub  input  1  0: A+B; 1: A-B.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result.
- out_carry  output  1  carry-out; for subtract, 1 means no borrow.

Behaviour:
- Two stages. S1 registers the selected A, the selected B and sub. S2 registers sum and carry.
- Latency: accepted at edge T gives out_valid=1 from edge T+2, provided there is no stall. Throughput is 1 op/cycle.
- Select rule: index < NUM_IN picks that candidate. Index >= NUM_IN (non-power-of-2 NUM_IN) yields an all-zero operand.
- Arithmetic: {carry,sum} = A + (sub ? ~B : B) + sub, computed at WIDTH+1 bits. Wrap-around is modulo 2^WIDTH. No overflow flag.
- Handshake:
  - s2_load = s1_valid & (!s2_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = !flush & (!s1_valid | s2_load). Combinational from out_ready; no combinational path from in_valid.
  - out_valid = s2_valid. out_sum/out_carry are held stable while out_valid & !out_ready.
  - A transfer occurs only when valid & ready are both high in the same cycle.
- Valid-bit update:
  - s1_valid' = s1_load | (s1_valid & !s2_load).
  - s2_valid' = s2_load | (s2_valid & !out_ready).
- Data registers load only on their stage's load condition; otherwise they hold. They are never cleared by flush.
- Flush, next edge: s1_valid=0 and s2_valid=0.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - A result presented with out_ready=1 in the flush cycle still counts as transferred.
- Reset, next edge: s1_valid=0, s2_valid=0, all data registers 0, out_sum=0, out_carry=0, out_valid=0. In-flight ops are discarded.
- Reset overrides flush and any handshake.
- in_ready may be 1 during reset; inputs offered then are dropped.
- Full-pipe stall: both valid with out_ready=0 gives in_ready=0. When out_ready rises, S2 drains, S1 advances and in_ready=1 in the same cycle (no bubble).
- Full throughput is sustained with out_ready held at 1.
- No X propagation: every register is reset.

Decomposition:
- Shared package pipe_arith_pkg:
  - OP_ADD=1'b0 and OP_SUB=1'b1 constants.
  - clog2-based SEL_W helper function.
  - DEFAULT_WIDTH=32.
- One sub-module, mux_n (combinational N-way select with the out-of-range-to-zero rule), instantiated twice. It is the parametrised replacement for the fixed 2:1/3:1 selectors.
- The adder stays inline; no separate instance.

Test Plan:
- Reset/latency: rst for 2 cycles, then one op with a_sel=1 (cand1=32'h0000_0010), b_sel=2 (cand2=32'h0000_0005), sub=0, out_ready=1 -> out_valid at T+2, out_sum=32'h15, out_carry=0. All outputs 0 during reset.
- Subtract/wrap: A=32'h0000_0003, B=32'h0000_0005, sub=1 -> out_sum=32'hFFFF_FFFE, out_carry=0. A=32'hFFFF_FFFF, B=1, sub=0 -> out_sum=0, out_carry=1.
- Back-pressure: stream 6 ops with out_ready=0 from cycle 3.
  - in_ready drops after 2 accepted; out_sum is stable while stalled.
  - Release out_ready -> all 6 results emerge in order with no loss or duplicate, one per cycle.
- Flush: 2 ops in flight, assert flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle, no result emerges, the next op is accepted the following cycle.
- Mid-operation reset: rst during a stalled full pipe -> out_valid=0 next edge, the pipe is empty, and the first post-reset op emerges after exactly 2 cycles.
- Out-of-range select: NUM_IN=3, SEL_W=2, a_sel=3, B=32'h7 -> out_sum=32'h7.
